// File: rtl/scan_sel_gen.sv
// scan_sel_gen: sequential select-code generator feeding a 3-to-8 decoder.
//
// Steps a 3-bit code through 0..7 (ascending) or 7..0 (descending) and holds
// each code for DWELL clocks. It supports single-pass and continuous scans,
// and a scan can be aborted. All outputs are registered.
//
// Parameters:
//   DWELL      clock cycles each code is held (1..65535)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      level-sampled start request, acted on only in IDLE
//   stop       abort request (SCAN -> IDLE; blocks start in IDLE)
//   dir        0 = ascending, 1 = descending; latched at start
//   cont       0 = single pass, 1 = wrap continuously; latched at start
//   skip_mask  (SCAN_SKIP_EN only) bit i = 1 suppresses code i; latched at start
//   sel_a      code bit 2 (MSB) -> decoder a
//   sel_b      code bit 1       -> decoder b
//   sel_c      code bit 0 (LSB) -> decoder c
//   sel_valid  high while the current code is being presented
//   busy       high in SCAN and DONE
//   done       one-cycle pulse at the end of a completed single pass
//
// Optional feature macro: SCAN_SKIP_EN. When it is undefined, the skip_mask
// port does not exist and the block behaves as if skip_mask were 8'h00.

module scan_sel_gen #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       cont,
`ifdef SCAN_SKIP_EN
  input  logic [7:0] skip_mask,
`endif
  output logic       sel_a,
  output logic       sel_b,
  output logic       sel_c,
  output logic       sel_valid,
  output logic       busy,
  output logic       done
);

  // The counter is at least 1 bit wide, so DWELL=1 still has a legal counter.
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e        state_q;
  logic [2:0]    code_q;
  logic [CW-1:0] cnt_q;
  logic          dir_q;
  logic          cont_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;

  logic [7:0]    mask_in;
  logic [7:0]    mask_q;

`ifdef SCAN_SKIP_EN
  assign mask_in = skip_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= 8'h00;
    end else if (state_q == StIdle && start && !stop) begin
      mask_q <= skip_mask;
    end
  end
`else
  assign mask_in = 8'h00;
  assign mask_q  = 8'h00;
`endif

  // Returns the next unmasked code after c in direction d. The search wraps
  // around, so it returns c itself when c is the only unmasked code.
  function automatic logic [2:0] next_code(input logic [2:0] c, input logic [7:0] m,
                                           input logic d);
    logic [2:0] n;
    logic [2:0] r;
    logic       found;
    n     = c;
    r     = c;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n = d ? n - 3'd1 : n + 3'd1;
      if (!found && !m[n]) begin
        r     = n;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  logic       all_masked;
  logic [2:0] first_code;
  logic [2:0] last_code;
  logic [2:0] adv_code;

  always_comb begin
    all_masked = &mask_in;
    // Start the search just before the first code of the scan direction.
    first_code = next_code(dir ? 3'd0 : 3'd7, mask_in, dir);
    // The last code is the first unmasked code found by searching backwards
    // from the end of the scan range.
    last_code  = next_code(dir_q ? 3'd7 : 3'd0, mask_q, ~dir_q);
    adv_code   = next_code(code_q, mask_q, dir_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= 3'd0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      cont_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            dir_q  <= dir;
            cont_q <= cont;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (all_masked) begin
              // No code is presentable: the pass completes immediately.
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StScan;
              code_q  <= first_code;
              valid_q <= 1'b1;
            end
          end
        end
        StScan: begin
          if (stop) begin
            state_q <= StIdle;
            code_q  <= 3'd0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CntMax) begin
            cnt_q <= '0;
            if (code_q == last_code && !cont_q) begin
              // sel_* keep the last code during DONE.
              state_q <= StDone;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // In continuous mode the last code wraps to the first code.
              code_q <= adv_code;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          code_q  <= 3'd0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sel_a     = code_q[2];
  assign sel_b     = code_q[1];
  assign sel_c     = code_q[0];
  assign sel_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
- Sequential select-code generator sitting directly upstream of the 3-to-8 decoder.
- Drives the decoder's a/b/c inputs, stepping through codes 0..7 (or 7..0) and holding each code for a programmable dwell time.
- Supports single-pass and continuous scanning, plus abort, for row/LED/keypad strobing.
- The decoder's one-hot outputs are valid whenever sel_valid is high.

Parameters:
- DWELL, 4, clock cycles each code is held; legal range 1..65535; counter width $clog2(DWELL), minimum 1 bit.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level-sampled start request; acted on only in IDLE.
- stop  input  1  abort request; acted on in SCAN and in IDLE (blocks start).
- dir  input  1  0 = ascending 0→7, 1 = descending 7→0; sampled at start and held for the whole scan.
- cont  input  1  0 = single pass, 1 = wrap continuously; sampled at start.
- sel_a  output  1  code bit 2 (MSB), drives decoder input a.
- sel_b  output  1  code bit 1, drives decoder input b.
- sel_c  output  1  code bit 0 (LSB), drives decoder input c.
- sel_valid  output  1  high while the current code is being presented.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse at the end of a completed single pass.

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered.
- Reset values: sel_a/b/c = 000, sel_valid = 0, busy = 0, done = 0, state = IDLE, dwell counter = 0, latched dir/cont = 0.
- Reset mid-scan takes effect immediately (asynchronously). There is no done pulse, and the block starts from IDLE after release.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - Outputs: sel = 000, sel_valid = 0, busy = 0.
  - start=1 and stop=0 in cycle N → SCAN. Latch dir/cont. Load the first code (000 if dir=0, 111 if dir=1) and clear the dwell counter.
  - From N+1: code on sel_*, sel_valid=1, busy=1.
  - start=1 with stop=1: stop wins; remain in IDLE.
- SCAN:
  - The dwell counter increments each cycle.
  - When the counter reaches DWELL-1, on the same edge: counter clears and the code advances (+1 if ascending, -1 if descending).
  - If the code was the last one (111 ascending, 000 descending):
    - cont=1: wrap to the first code; no gap, no done.
    - cont=0: → DONE; sel_valid=0 from the next cycle; sel_* are held at the last code.
  - Each code is therefore visible for exactly DWELL cycles. A single pass lasts 8*DWELL cycles of sel_valid.
  - stop=1 in any SCAN cycle → IDLE on the next edge (sel_*=000, sel_valid=0, busy=0, no done). stop has priority over code advance.
  - start is ignored while in SCAN. Changes to dir/cont during the scan are ignored.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, sel_valid=0; then → IDLE.
  - start in DONE is ignored; a new scan needs start sampled in IDLE.
  - Back-to-back timing: start held high gives done at cycle M; IDLE at M+1 samples start; SCAN at M+2.
- Single-pass latency: start sampled at edge N → first code at N+1; done high in cycle N+1+8*DWELL.
- DWELL=1: the code changes every cycle. The counter logic must not underflow at this boundary.
- With DWELL=1, cont=1, dir=0: sel sequence is 0,1,...,7,0,1,... with no bubble.

Optional Feature:
- Macro SCAN_SKIP_EN.
- Defined:
  - Adds input skip_mask[7:0], sampled at start; bit i=1 means code i is never presented.
  - The first code is the first unmasked code in the scan direction.
  - Advance goes to the next unmasked code in the direction. The "last code" for pass end/wrap is the final unmasked code in the direction.
  - Each emitted code still dwells DWELL cycles.
  - If all 8 bits are masked: start → DONE directly. done pulses at N+1, sel_valid is never asserted (with cont=1 as well), then IDLE.
  - A single pass lasts popcount(~mask)*DWELL cycles.
- Undefined: port absent; behaviour identical to skip_mask=8'h00.

Test Plan:
- Reset mid-scan: DWELL=4, dir=0, cont=0, rst_n low while code=5 → outputs 000/0/0/0 immediately. Release, start again → begins at 000.
- Single pass up: DWELL=4, dir=0, cont=0, start pulse at cycle 10 → sel = 0..7, each 4 cycles over cycles 11..42; done=1 only at cycle 43; busy 11..43.
- Descending continuous: DWELL=1, dir=1, cont=1 → sel 7,6,...,0,7,6,... with no gap and done never asserted. stop at an arbitrary cycle → next cycle IDLE, sel_valid=0, no done.
- Boundaries: start and stop both high in IDLE → stays IDLE. start held constantly with cont=0, DWELL=2 → done, one IDLE cycle, new scan starting at 000. Toggling dir mid-scan has no effect.
- SCAN_SKIP_EN:
  - skip_mask=8'b1010_0101, dir=0, DWELL=2 → sel 1,3,4,6, each 2 cycles, then done.
  - skip_mask=8'hFF → done pulse one cycle after start; sel_valid stays 0.
